// File: rtl/serial_ripple_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_ripple_subtractor_if
//
// Purpose: bundles the start/busy/done handshake, the operand bus and the
// result bus of the bit-serial subtractor into one interface.
//
// Signals:
//   start  request, driven by the master
//   A, B   minuend / subtrahend (WIDTH bits), driven by the master
//   Bin    borrow-in, driven by the master
//   D      difference (WIDTH bits), driven by the slave
//   Bout   final borrow-out, driven by the slave
//   busy   high while bits are being processed, driven by the slave
//   done   one-cycle result-valid pulse, driven by the slave
//   V      signed overflow flag, driven by the slave
//          (present only when SERIAL_SUB_OVERFLOW_EN is defined)
//
// Modports:
//   master  the requester (drives operands, reads results)
//   slave   the subtractor itself
// ---------------------------------------------------------------------------
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             V;
`endif

`ifdef SERIAL_SUB_OVERFLOW_EN
  modport master (output start, A, B, Bin, input D, Bout, busy, done, V);
  modport slave  (input start, A, B, Bin, output D, Bout, busy, done, V);
`else
  modport master (output start, A, B, Bin, input D, Bout, busy, done);
  modport slave  (input start, A, B, Bin, output D, Bout, busy, done);
`endif
endinterface

// File: rtl/serial_ripple_subtractor.sv
// ---------------------------------------------------------------------------
// serial_ripple_subtractor
//
// Purpose: bit-serial subtractor computing D = A - B - Bin over WIDTH bits,
// one bit per clock, LSB first, through a single full-subtractor cell and a
// registered borrow. It is the checking partner of the ripple-carry adder:
// (A + B) - B must return A.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high; overrides everything, aborts a
//         running operation without a done pulse
//   bus   serial_ripple_subtractor_if.slave
//           start      request, sampled only in IDLE or DONE
//           A, B, Bin  operands, captured on the accepted start
//           D, Bout    result, loaded when done rises and held until the
//                      next completed operation (or reset)
//           busy       high during the WIDTH processing cycles
//           done       one-cycle pulse when D/Bout become valid
//           V          signed overflow flag (SERIAL_SUB_OVERFLOW_EN only)
//
// Parameters:
//   WIDTH  operand/result width, must be >= 2
//
// Configuration macro:
//   SERIAL_SUB_OVERFLOW_EN  adds the signed overflow output V
//
// Timing: start accepted at edge 0, bits processed on edges 1..WIDTH,
// done high between edge WIDTH and WIDTH+1; one result every WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_ripple_subtractor_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             v_q, v_d;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shift;

  // The full-subtractor cell. The operand registers shift right every RUN
  // cycle, so bit 0 is always the bit currently being processed. The result
  // enters at the MSB end, so after WIDTH shifts the first (LSB) result bit
  // has travelled down to bit 0 and the word is in natural order.
  always_comb begin
    a_bit     = a_q[0];
    b_bit     = b_q[0];
    d_bit     = a_bit ^ b_bit ^ br_q;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_shift = {d_bit, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control. IDLE and DONE behave the same way on a
  // start (capture and run), which is what makes back-to-back operation
  // possible with exactly one DONE cycle between results. Without a start,
  // both fall to IDLE. D/Bout only change on the last RUN edge, so they hold
  // through IDLE and across a following RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    v_d     = v_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = bus.Bin;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = bus.A[WIDTH-1];
          b_msb_d = bus.B[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          d_d     = res_shift;
          bout_d  = br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // Signed overflow: operands of opposite sign and a result whose
          // sign differs from the minuend.
          v_d     = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
`endif
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset is synchronous and clears the
  // result too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      v_q     <= v_d;
`endif
    end
  end

  // Outputs come straight from registers (busy/done are decodes of the
  // state register), so nothing on the input side reaches them within a
  // cycle.
  always_comb begin
    bus.D    = d_q;
    bus.Bout = bout_q;
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
`ifdef SERIAL_SUB_OVERFLOW_EN
    bus.V    = v_q;
`endif
  end

endmodule
